// File: rtl/mem_latency_injector_mq.sv
// ---------------------------------------------------------------------------
// mem_latency_injector_mq
// Multi-outstanding memory latency model for NPU performance simulation.
// Tagged SRAM/DRAM requests enter a DEPTH-entry in-order queue. Each entry
// latches a latency when it is pushed and counts it down. Responses leave in
// order under valid/ready once the head entry has expired. Traffic counters
// feed perf reports.
//
// Optional feature macro: MLI_JITTER_EN
//   defined   : a 16-bit Fibonacci LFSR (taps 16,14,13,11) adds
//               lfsr[JITTER_BITS-1:0] to every DRAM latency (saturating).
//   undefined : no LFSR; latency is exactly the selected value.
//
// Ports
//   clk, reset               clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready = queue not full)
//   req_is_dram              request target, 1=DRAM 0=SRAM
//   req_size_bytes, req_tag  request payload
//   resp_valid/resp_ready    response handshake for the head entry
//   resp_tag, resp_size_bytes, resp_is_dram   head entry payload
//   cfg_latency_sram/dram    runtime latencies
//   cfg_use_cfg_latencies    1=use cfg_* latencies, 0=use parameters
//   total_reqs .. busy_cycles 32-bit wrapping traffic counters
//   outstanding, busy        current occupancy and occupancy != 0
// ---------------------------------------------------------------------------
module mem_latency_injector_mq #(
  parameter int          DEPTH               = 8,
  parameter int          TAG_W               = 4,
  parameter int          SIZE_W              = 16,
  parameter int          LAT_W               = 16,
  parameter int          LATENCY_SRAM_CYCLES = 2,
  parameter int          LATENCY_DRAM_CYCLES = 12,
  parameter int          JITTER_BITS         = 3,
  parameter logic [15:0] JITTER_SEED         = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_is_dram,
  input  logic [SIZE_W-1:0]        req_size_bytes,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [TAG_W-1:0]         resp_tag,
  output logic [SIZE_W-1:0]        resp_size_bytes,
  output logic                     resp_is_dram,
  input  logic [LAT_W-1:0]         cfg_latency_sram,
  input  logic [LAT_W-1:0]         cfg_latency_dram,
  input  logic                     cfg_use_cfg_latencies,
  output logic [31:0]              total_reqs,
  output logic [31:0]              total_resp,
  output logic [31:0]              sram_reqs,
  output logic [31:0]              dram_reqs,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              busy_cycles,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Queue storage
  logic [TAG_W-1:0]  r_tag  [DEPTH];
  logic [SIZE_W-1:0] r_size [DEPTH];
  logic              r_dram [DEPTH];
  logic [LAT_W-1:0]  r_rem  [DEPTH];

  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic [31:0] r_total_reqs;
  logic [31:0] r_total_resp;
  logic [31:0] r_sram_reqs;
  logic [31:0] r_dram_reqs;
  logic [31:0] r_stall_cycles;
  logic [31:0] r_busy_cycles;

  logic             w_push;
  logic             w_pop;
  logic             w_resp_valid;
  logic [LAT_W-1:0] w_sel;
  logic [LAT_W-1:0] w_lat_base;
  logic [LAT_W-1:0] w_lat;

  // Ready depends on registered occupancy only: a full queue stays not-ready
  // even when the head pops in the same cycle.
  assign req_ready    = (r_count < CNT_W'(DEPTH));
  assign w_push       = req_valid && req_ready;
  assign w_resp_valid = (r_count != '0) && (r_rem[r_rptr] == '0);
  assign w_pop        = w_resp_valid && resp_ready;

`ifdef MLI_JITTER_EN
  logic [15:0]    r_lfsr;
  logic           w_lfsr_fb;
  logic [LAT_W:0] w_lat_sum;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= JITTER_SEED;
    else       r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
  end
`else
  // The jitter parameters have no function when the LFSR is compiled out.
  logic w_unused_jitter_cfg;
  assign w_unused_jitter_cfg = ^{JITTER_SEED, 8'(JITTER_BITS)};
`endif

  // Latency chosen at push time; a zero selection is clamped to one cycle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sel = '0;
    if (req_is_dram) begin
      w_sel = cfg_use_cfg_latencies ? cfg_latency_dram : LAT_W'(LATENCY_DRAM_CYCLES);
    end else begin
      w_sel = cfg_use_cfg_latencies ? cfg_latency_sram : LAT_W'(LATENCY_SRAM_CYCLES);
    end
    w_lat_base = (w_sel == '0) ? LAT_W'(1) : w_sel;
`ifdef MLI_JITTER_EN
    w_lat_sum = {1'b0, w_lat_base} + (LAT_W + 1)'(r_lfsr[JITTER_BITS-1:0]);
    if (req_is_dram) begin
      w_lat = w_lat_sum[LAT_W] ? '1 : w_lat_sum[LAT_W-1:0];
    end else begin
      w_lat = w_lat_base;
    end
`else
    w_lat = w_lat_base;
`endif
  end

  // Entry storage and countdowns. A countdown loaded with L-1 at the push edge
  // reaches zero L cycles after the handshake cycle.
  // NOTE: the storage arrays are not reset; occupancy gates every read, so
  // stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (r_rem[i] != '0) r_rem[i] <= r_rem[i] - LAT_W'(1);
    end
    if (w_push) begin
      r_rem[r_wptr]  <= w_lat - LAT_W'(1);
      r_tag[r_wptr]  <= req_tag;
      r_size[r_wptr] <= req_size_bytes;
      r_dram[r_wptr] <= req_is_dram;
    end
  end

  // Pointers, occupancy and counters.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_total_reqs   <= '0;
      r_total_resp   <= '0;
      r_sram_reqs    <= '0;
      r_dram_reqs    <= '0;
      r_stall_cycles <= '0;
      r_busy_cycles  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push) begin
        r_total_reqs <= r_total_reqs + 32'd1;
        if (req_is_dram) r_dram_reqs <= r_dram_reqs + 32'd1;
        else             r_sram_reqs <= r_sram_reqs + 32'd1;
      end
      if (w_pop)                   r_total_resp   <= r_total_resp + 32'd1;
      if (req_valid && !req_ready) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (r_count != '0)           r_busy_cycles  <= r_busy_cycles + 32'd1;
    end
  end

  assign resp_valid      = w_resp_valid;
  assign resp_tag        = w_resp_valid ? r_tag[r_rptr]  : '0;
  assign resp_size_bytes = w_resp_valid ? r_size[r_rptr] : '0;
  assign resp_is_dram    = w_resp_valid ? r_dram[r_rptr] : 1'b0;

  assign total_reqs   = r_total_reqs;
  assign total_resp   = r_total_resp;
  assign sram_reqs    = r_sram_reqs;
  assign dram_reqs    = r_dram_reqs;
  assign stall_cycles = r_stall_cycles;
  assign busy_cycles  = r_busy_cycles;
  assign outstanding  = r_count;
  assign busy         = (r_count != '0);

endmodule

// File: tb/tb_mem_latency_injector_mq.sv
// ---------------------------------------------------------------------------
// tb_mem_latency_injector_mq
// Self-checking bench for mem_latency_injector_mq. A queue-of-requests model
// (each entry carries the cycle in which it becomes releasable) is compared
// against the DUT on every falling edge; directed scenarios add hand-computed
// literal expectations. Build with MLI_JITTER_EN to add the jitter scenario.
// ---------------------------------------------------------------------------
module tb_mem_latency_injector_mq;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_dram = 1'b0;
  logic [15:0] req_size_bytes = '0;
  logic [3:0]  req_tag = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [3:0]  resp_tag;
  logic [15:0] resp_size_bytes;
  logic        resp_is_dram;
  logic [15:0] cfg_latency_sram = 16'd2;
  logic [15:0] cfg_latency_dram = 16'd10;
  logic        cfg_use_cfg_latencies = 1'b1;
  logic [31:0] total_reqs, total_resp, sram_reqs, dram_reqs, stall_cycles, busy_cycles;
  logic [3:0]  outstanding;
  logic        busy;

  mem_latency_injector_mq dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_dram(req_is_dram),
    .req_size_bytes(req_size_bytes), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag),
    .resp_size_bytes(resp_size_bytes), .resp_is_dram(resp_is_dram),
    .cfg_latency_sram(cfg_latency_sram), .cfg_latency_dram(cfg_latency_dram),
    .cfg_use_cfg_latencies(cfg_use_cfg_latencies),
    .total_reqs(total_reqs), .total_resp(total_resp), .sram_reqs(sram_reqs),
    .dram_reqs(dram_reqs), .stall_cycles(stall_cycles), .busy_cycles(busy_cycles),
    .outstanding(outstanding), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]  tag;
    logic [15:0] size;
    logic        dram;
    int          ready_cyc;
  } ent_t;

  ent_t        m_q[$];
  int          cyc = 0;
  int unsigned m_reqs, m_resp, m_sram, m_dram, m_stall, m_busy;
  logic [15:0] m_lfsr = 16'hACE1;
  bit          m_push, m_pop, m_valid;

  function automatic int lat_of(input logic dram);
    int sel;
    if (cfg_use_cfg_latencies) sel = dram ? int'(cfg_latency_dram) : int'(cfg_latency_sram);
    else                       sel = dram ? 12 : 2;
    if (sel == 0) sel = 1;
`ifdef MLI_JITTER_EN
    if (dram) begin
      sel = sel + int'(m_lfsr[2:0]);
      if (sel > 65535) sel = 65535;
    end
`endif
    return sel;
  endfunction

  function automatic bit model_valid();
    return (m_q.size() > 0) ? (m_q[0].ready_cyc <= cyc) : 1'b0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_reqs = 0; m_resp = 0; m_sram = 0; m_dram = 0; m_stall = 0; m_busy = 0;
      m_lfsr = 16'hACE1;
    end else begin
      m_valid = model_valid();
      m_push  = req_valid && (m_q.size() < DEPTH);
      m_pop   = m_valid && resp_ready;
      if (req_valid && !m_push) m_stall++;
      if (m_q.size() != 0)      m_busy++;
      if (m_pop) begin
        void'(m_q.pop_front());
        m_resp++;
      end
      if (m_push) begin
        m_q.push_back('{tag: req_tag, size: req_size_bytes, dram: req_is_dram,
                        ready_cyc: cyc + lat_of(req_is_dram)});
        m_reqs++;
        if (req_is_dram) m_dram++; else m_sram++;
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      cyc++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("req_ready",    req_ready,    m_q.size() < DEPTH);
      check("resp_valid",   resp_valid,   model_valid());
      check("outstanding",  outstanding,  m_q.size());
      check("busy",         busy,         m_q.size() != 0);
      check("total_reqs",   total_reqs,   m_reqs);
      check("total_resp",   total_resp,   m_resp);
      check("sram_reqs",    sram_reqs,    m_sram);
      check("dram_reqs",    dram_reqs,    m_dram);
      check("stall_cycles", stall_cycles, m_stall);
      check("busy_cycles",  busy_cycles,  m_busy);
      if (model_valid()) begin
        check("resp_tag",     resp_tag,        m_q[0].tag);
        check("resp_size",    resp_size_bytes, m_q[0].size);
        check("resp_is_dram", resp_is_dram,    m_q[0].dram);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_resp_valid",  resp_valid, 0);
    check("rst_req_ready",   req_ready, 1);
    check("rst_busy",        busy, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_resp_tag",    resp_tag, 0);
    check("rst_resp_size",   resp_size_bytes, 0);
    check("rst_resp_dram",   resp_is_dram, 0);
    check("rst_counters",    {total_reqs | total_resp | sram_reqs | dram_reqs |
                              stall_cycles | busy_cycles}, 0);
    tick();
    reset = 1'b0;
  endtask

  // Offer one request in the current cycle; c is the handshake cycle.
  task automatic push_one(input logic dram, input logic [3:0] tag,
                          input logic [15:0] size, output int c);
    req_valid = 1'b1; req_is_dram = dram; req_tag = tag; req_size_bytes = size;
    c = cyc;
    tick();
    req_valid = 1'b0;
  endtask

  // Wait for resp_valid (resp_ready assumed high), report its cycle and tag.
  task automatic wait_resp(input int budget, output int c, output logic [3:0] tag);
    int n = 0;
    while (!resp_valid && n < budget) begin
      tick();
      n++;
    end
    if (!resp_valid) begin
      check("resp_timeout", 0, 1);
      c = -1; tag = '0;
    end else begin
      c = cyc; tag = resp_tag;
      tick();
    end
  endtask

  int         c0, c1, rc, first_c;
  logic [3:0] rt;

  initial begin
    tick(); tick();
    reset = 1'b0;
    tick();

    // 1: single SRAM request, latency 2
    push_one(1'b0, 4'd3, 16'd32, c0);
    check("t1_not_early", resp_valid, 0);
    tick();
    check("t1_valid_c+2", resp_valid, 1);
    check("t1_tag",       resp_tag, 3);
    check("t1_size",      resp_size_bytes, 32);
    tick();
    check("t1_total_reqs", total_reqs, 1);
    check("t1_total_resp", total_resp, 1);
    check("t1_sram_reqs",  sram_reqs, 1);

    // 2: four back-to-back DRAM requests, latency 10
    do_reset();
    req_valid = 1'b1; req_is_dram = 1'b1; req_size_bytes = 16'd64;
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      req_tag = 4'(i);
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_resp(30, rc, rt);
      check("t2_resp_cycle", rc, c0 + 10 + i);
      check("t2_resp_tag",   rt, i);
    end
    check("t2_dram_reqs", dram_reqs, 4);

    // 3: fill to DEPTH with resp_ready low, then drain at full rate
    do_reset();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_is_dram = 1'b0; req_size_bytes = 16'd8;
    for (int i = 0; i < 10; i++) begin
      req_tag = 4'(i);
      tick();
    end
    req_valid = 1'b0;
    check("t3_outstanding", outstanding, 8);
    check("t3_stall",       stall_cycles, 2);
    check("t3_req_ready",   req_ready, 0);
    resp_ready = 1'b1;
    first_c = cyc;
    for (int i = 0; i < 8; i++) begin
      wait_resp(5, rc, rt);
      check("t3_drain_cycle", rc, first_c + i);
      check("t3_drain_tag",   rt, i);
    end
    check("t3_empty", outstanding, 0);

    // 4: DRAM then SRAM; SRAM waits behind DRAM; later cfg change ignored
    do_reset();
    push_one(1'b1, 4'd5, 16'd64, c0);
    cfg_latency_dram = 16'd3;
    push_one(1'b0, 4'd6, 16'd8, c1);
    wait_resp(20, rc, rt);
    check("t4_dram_cycle", rc, c0 + 10);
    check("t4_dram_tag",   rt, 5);
    wait_resp(5, rc, rt);
    check("t4_sram_cycle", rc, c0 + 11);
    check("t4_sram_tag",   rt, 6);
    cfg_latency_dram = 16'd10;

    // 5a: zero SRAM latency clamps to 1
    cfg_latency_sram = 16'd0;
    push_one(1'b0, 4'd7, 16'd1, c0);
    check("t5_lat1_valid", resp_valid, 1);
    check("t5_lat1_tag",   resp_tag, 7);
    tick();
    cfg_latency_sram = 16'd2;

    // 5b: parameter latencies
    cfg_use_cfg_latencies = 1'b0;
    push_one(1'b1, 4'd8, 16'd2, c0);
    wait_resp(20, rc, rt);
    check("t5_param_dram_cycle", rc, c0 + 12);
    cfg_use_cfg_latencies = 1'b1;

    // 5c: reset with three entries in flight
    resp_ready = 1'b0;
    req_valid = 1'b1; req_is_dram = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_tag = 4'(i);
      tick();
    end
    req_valid = 1'b0;
    check("t5_three_outstanding", outstanding, 3);
    do_reset();
    resp_ready = 1'b1;
    tick();

    // 6: mixed traffic with changing configuration, checked by the model
    for (int i = 0; i < 300; i++) begin
      if (i % 60 == 0) begin
        cfg_use_cfg_latencies = 1'($urandom_range(0, 1));
        cfg_latency_sram = 16'($urandom_range(0, 4));
        cfg_latency_dram = 16'($urandom_range(0, 8));
      end
      req_valid      = 1'($urandom_range(0, 1));
      req_is_dram    = 1'($urandom_range(0, 1));
      req_tag        = 4'($urandom);
      req_size_bytes = 16'($urandom);
      resp_ready     = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 200 && outstanding != 0; i++) tick();
    check("t6_drained", outstanding, 0);

`ifdef MLI_JITTER_EN
    // 7: jittered DRAM latency stays within [10,17] and varies
    begin
      bit seen[int];
      int lat;
      cfg_use_cfg_latencies = 1'b1;
      cfg_latency_dram = 16'd10;
      for (int i = 0; i < 64; i++) begin
        push_one(1'b1, 4'(i), 16'd4, c0);
        wait_resp(40, rc, rt);
        lat = rc - c0;
        check("t7_lat_in_range", (lat >= 10 && lat <= 17), 1);
        seen[lat] = 1'b1;
      end
      check("t7_distinct_ge2", seen.num() >= 2, 1);
    end
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
